shift_right_seq: RTL and testbench
==================================

SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 Parameter: WIDTH, default 32, data width in bits.
REQ-002 Parameter: SHW, default 5, shift-amount width; SHALL satisfy 2**SHW == WIDTH.
REQ-003 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port: reset, input, 1, asynchronous active-high reset.
REQ-005 Port: start, input, 1, request pulse; sampled only on rising clk edges.
REQ-006 Port: in, input, WIDTH, operand captured when start is accepted.
REQ-007 Port: shamt, input, SHW, right-shift amount captured with in.
REQ-008 Port: arith, input, 1, captured with in: 1 = arithmetic (sign fill), 0 = logical (zero fill).
REQ-009 Port: out, output, WIDTH, shift result register.
REQ-010 Port: busy, output, 1, high while in SHIFT.
REQ-011 Port: done, output, 1, one-cycle completion strobe.

Function
REQ-012 The block SHALL be an FSM with exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE or DONE, start=1 at edge N SHALL capture in, shamt and arith, load out with in, and load an internal counter with shamt.
REQ-014 On acceptance, the next state SHALL be SHIFT if shamt != 0, and DONE if shamt == 0.
REQ-015 In SHIFT, each edge SHALL shift out right by exactly one bit and decrement the counter by one.
REQ-016 The fill bit SHALL be out[WIDTH-1] when arith=1 and 0 when arith=0.
REQ-017 In SHIFT, when the counter equals 1, the shift SHALL occur and the next state SHALL be DONE.
REQ-018 Latency: with start accepted at edge N, done SHALL be high for exactly the cycle following edge N+shamt (after edge N for shamt=0).
REQ-019 done SHALL be high only in DONE; DONE SHALL last one cycle and then go to IDLE, or reload per REQ-013 if start=1.
REQ-020 busy SHALL equal (state == SHIFT).
REQ-021 start SHALL be ignored while in SHIFT; captured operands and progress SHALL be unaffected.
REQ-022 in, shamt and arith changes after acceptance SHALL have no effect on the current operation.
REQ-023 out SHALL hold the final result from DONE through IDLE until the next accepted start.
REQ-024 out SHALL equal in >> shamt (logical) or in >>> shamt (arithmetic) when done is high, for all shamt 0..WIDTH-1.
REQ-025 Back-to-back: start=1 during the DONE cycle SHALL be accepted with no idle bubble; done is still high in that cycle.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, out=0, counter=0, busy=0 and done=0.
REQ-027 reset asserted mid-SHIFT SHALL abort the operation; no done SHALL be produced for it.
REQ-028 A start sampled on the first edge after reset deassertion SHALL be accepted normally.

Verification
REQ-029 Scenario: in=0x2345F000, shamt=2, arith=0 -> busy high for 2 cycles; done after edge N+2; out=0x08D17C00.
REQ-030 Scenario: in=0x80000000, shamt=4, first with arith=1 then with arith=0 -> out=0xF8000000, then out=0x08000000.
REQ-031 Scenario: in=0xFFFFFFFF, shamt=31, first with arith=0 then with arith=1 -> out=0x00000001 after 31 busy cycles, then out=0xFFFFFFFF.
REQ-032 Scenario: shamt=0, in=0xAAAA9999 -> busy never high; done after edge N; out=0xAAAA9999.
REQ-033 Scenario: start pulsed mid-SHIFT with a different in, then start held during the DONE cycle -> the first result is unchanged; the second operation begins with no bubble.
REQ-034 Scenario: reset asserted between clk edges during SHIFT -> out=0 and busy=0 at once; no done appears; the next start completes correctly.

Source files
------------

// File: rtl/shift_right_seq.sv
// Sequential right shifter: moves the operand one bit per clock, with zero or
// sign fill, and strobes done once the requested shift amount has been applied.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; out holds the last result (0 after reset)
// SHIFT | one-bit shift per edge; cnt_q holds the shifts still to apply
// DONE  | result valid in out, done high for this cycle; start reloads
module shift_right_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             arith_q, arith_d;
    logic             fill;

    assign fill = arith_q & out_q[WIDTH-1];

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        arith_d = arith_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    out_d   = in;
                    cnt_d   = shamt;
                    arith_d = arith;
                    // A zero shift skips SHIFT so done follows the accepting edge.
                    state_d = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                out_d = {fill, out_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            arith_q <= arith_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: hand-computed results, latency, busy
// length, start-ignored-in-SHIFT, back-to-back reload and async reset abort.
module tb_shift_right_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] din;
    logic [4:0]  dsh;
    logic        dar;
    logic [31:0] dout;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    shift_right_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (din),
        .shamt (dsh),
        .arith (dar),
        .out   (dout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at #1 after the accepting edge; counts edges until done shows.
    task automatic wait_done(input string tag, input int sh, input logic [31:0] exp);
        int k  = 0;
        int nb = 0;
        while (!done && k < 40) begin
            if (busy) nb++;
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "/done"}, {31'd0, done}, 32'd1);
        check({tag, "/lat"}, k, sh);
        check({tag, "/busy_len"}, nb, sh);
        check({tag, "/out"}, dout, exp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                          input logic ar, input logic [31:0] exp);
        @(negedge clk);
        start = 1'b1;
        din   = a;
        dsh   = sh;
        dar   = ar;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = ~a;
        dsh   = ~sh;
        dar   = ~ar;
        wait_done(tag, int'(sh), exp);
        @(posedge clk);
        #1;
        check({tag, "/done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "/idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "/hold"}, dout, exp);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        din   = 32'h0;
        dsh   = 5'd0;
        dar   = 1'b0;
        #1;
        check("rst/out", dout, 32'h0);
        check("rst/busy", {31'd0, busy}, 32'd0);
        check("rst/done", {31'd0, done}, 32'd0);
        #16;
        reset = 1'b0;

        run_op("lsr2",      32'h2345F000, 5'd2,  1'b0, 32'h08D17C00);
        run_op("asr4",      32'h80000000, 5'd4,  1'b1, 32'hF8000000);
        run_op("lsr4",      32'h80000000, 5'd4,  1'b0, 32'h08000000);
        run_op("lsr31",     32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001);
        run_op("asr31",     32'hFFFFFFFF, 5'd31, 1'b1, 32'hFFFFFFFF);
        run_op("sh0",       32'hAAAA9999, 5'd0,  1'b0, 32'hAAAA9999);
        run_op("asr31_pos", 32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000);
        run_op("asr1",      32'h80000001, 5'd1,  1'b1, 32'hC0000000);

        // start pulsed mid-SHIFT is ignored, then start held in DONE reloads at once
        @(negedge clk);
        start = 1'b1; din = 32'hF0F0F0F0; dsh = 5'd8; dar = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; din = 32'h12345678; dsh = 5'd1; dar = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("midstart", 5, 32'hFFF0F0F0);
        start = 1'b1; din = 32'h12345678; dsh = 5'd4; dar = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; din = 32'h0; dsh = 5'd0;
        check("b2b/busy", {31'd0, busy}, 32'd1);
        check("b2b/done_low", {31'd0, done}, 32'd0);
        wait_done("b2b", 4, 32'h01234567);

        // async reset between edges during SHIFT
        @(negedge clk);
        start = 1'b1; din = 32'hFFFFFFFF; dsh = 5'd20; dar = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst/out", dout, 32'h0);
        check("arst/busy", {31'd0, busy}, 32'd0);
        check("arst/done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("arst/no_done", {31'd0, done | busy}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1; din = 32'h2345F000; dsh = 5'd2; dar = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("post_rst", 2, 32'h08D17C00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
